ddr2_host_intake: RTL
=====================

Name: ddr2_host_intake

Overview:
- Host-facing command/data intake of the DDR2 controller. It is the receiving end of the command interface that test drivers and host masters use.
- Decodes the cmd/sz/op/addr/din bus and accepts commands into a command FIFO and a write-data FIFO.
- Reports fillcount/notfull back-pressure to the host and presents queued commands and write data to the downstream scheduler over valid/ready handshakes.
- Sequences block-write data beats that follow a BLW command.

Parameters:
- CMD_DEPTH, 16, command FIFO entries (power of 2).
- DATA_DEPTH, 64, write-data FIFO entries (power of 2, <=64, so fillcount fits 7 bits).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd  in  3  host command: 0/7 NOP, 1 SCR, 2 SCW, 3 BLR, 4 BLW, 5 ATR, 6 ATW.
- sz  in  2  block size; burst = 8*(sz+1) words.
- op  in  3  atomic opcode.
- addr  in  25  host address.
- din  in  16  write data.
- fetching  in  1  host signals no further commands.
- fillcount  out  7  write-data FIFO occupancy, 0..DATA_DEPTH.
- notfull  out  1  command FIFO has a free entry.
- q_valid  out  1  command FIFO non-empty.
- q_ready  in  1  scheduler pops command.
- q_cmd  out  3, q_sz out 2, q_op out 3, q_addr out 25  head-of-queue command fields.
- wd_valid  out  1  data FIFO non-empty.
- wd_ready  in  1  scheduler pops data word.
- wd_data  out  16  head data word.
- blk_active  out  1  in block-write data phase.
- drained  out  1  fetching seen, idle, both FIFOs empty.

Behaviour:
- Reset (reset=0, async): both FIFOs empty, all pointers and counters 0, state IDLE. Outputs: fillcount=0, notfull=1, q_valid=0, wd_valid=0, blk_active=0, drained=0. q_* and wd_data=0.
- Status flags: cspace = notfull, i.e. cmd count < CMD_DEPTH. dspace = data count < DATA_DEPTH.
  - All acceptance decisions use the counts registered at the start of the cycle. A same-cycle pop never enables a push.
- States: IDLE, BLK.
- IDLE, evaluated each rising edge:
  - cmd 0/7: nothing pushed.
  - cmd 1/3: push {cmd,sz,op,addr} if cspace.
  - cmd 2/5/6: push command and din only if cspace && dspace. Both are pushed or neither.
  - cmd 4: if cspace && dspace, push command and din, load beat_cnt = 8*(sz+1)-1 (7/15/23/31), go to BLK.
  - Unaccepted commands: host holds the inputs; the block keeps no memory of them.
- BLK:
  - cmd/sz/op/addr are ignored.
  - Each edge with dspace: push din, decrement beat_cnt.
  - Push with beat_cnt==1: go to IDLE next cycle.
  - No dspace: stall, counter unchanged.
  - blk_active=1 throughout BLK.
- Push latency: pushed entry is visible at the FIFO head (q_valid/wd_valid) the cycle after the push edge, if the FIFO was empty.
- Pop: on edge where q_valid && q_ready, advance the command head. Same rule for wd_valid && wd_ready. q_ready/wd_ready with FIFO empty is ignored.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointer wrap: pointers are log2(depth) bits and wrap modulo depth. Count is held separately, width log2(depth)+1.
- fillcount and notfull are registered and update the cycle after each push/pop.
- fetching: sticky flag set on any edge where fetching=1.
  - drained = flag && IDLE && both counts 0.
  - Cleared only by reset.
- Command FIFO data is not reset-sensitive beyond pointers. Outputs q_*/wd_data show the head entry only while valid; otherwise they are 0.
- Reset mid-BLK: all queued commands and partial burst data are discarded, state returns to IDLE.

Test Plan:
- SCW cmd=2 addr=0x08F07A din=0xFACE, then SCR cmd=1 addr=0x2E3B9, q_ready=1, wd_ready=1 → q_cmd 2 then 1 with matching addr. wd_data=0xFACE once. fillcount returns 0.
- BLW cmd=4 sz=1 with din incrementing from 0x0100, wd_ready=0 → blk_active for 15 further edges, fillcount=16, data FIFO contents 0x0100..0x010F in order, IDLE afterwards.
- Hold wd_ready=0 and issue 64 SCW → fillcount=64. A 65th SCW is not accepted; its command is not queued (command FIFO count unchanged). One pop, then the SCW is accepted next edge.
- Issue 16 SCR with q_ready=0 → notfull=0, 17th not queued. Pop and push in the same cycle while full → push still refused that cycle.
- BLW sz=3, assert reset after 10 data beats → all counts 0, notfull=1, fillcount=0, blk_active=0. A following SCR is accepted normally.
- fetching=1 with NOP while 3 commands are queued → drained stays 0 until all pops complete, then 1 and held.

Source files
------------

// File: rtl/ddr2_host_intake.sv
// ddr2_host_intake
// Host-facing intake for the DDR2 controller. It decodes host commands into a
// command FIFO and a write-data FIFO, reports back-pressure to the host, runs
// the beat sequencing for block writes, and hands queued entries to the
// scheduler over valid/ready handshakes.
module ddr2_host_intake #(
  parameter int CMD_DEPTH  = 16,
  parameter int DATA_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cmd,
  input  logic [1:0]  sz,
  input  logic [2:0]  op,
  input  logic [24:0] addr,
  input  logic [15:0] din,
  input  logic        fetching,
  output logic [6:0]  fillcount,
  output logic        notfull,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [2:0]  q_cmd,
  output logic [1:0]  q_sz,
  output logic [2:0]  q_op,
  output logic [24:0] q_addr,
  output logic        wd_valid,
  input  logic        wd_ready,
  output logic [15:0] wd_data,
  output logic        blk_active,
  output logic        drained
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int DAW = $clog2(DATA_DEPTH);

  localparam logic [CAW:0] CMD_FULL  = (CAW+1)'(CMD_DEPTH);
  localparam logic [DAW:0] DATA_FULL = (DAW+1)'(DATA_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BLK  = 1'b1;

  // One command entry: {cmd, sz, op, addr}
  localparam int CW = 3 + 2 + 3 + 25;

  logic [0:0]     state_q, state_d;
  logic [4:0]     beat_q, beat_d;
  logic [CAW-1:0] cWr_q, cRd_q;
  logic [CAW:0]   cCnt_q, cCnt_d;
  logic [DAW-1:0] dWr_q, dRd_q;
  logic [DAW:0]   dCnt_q, dCnt_d;
  logic           notfull_q;
  logic           fetch_q;

  logic [CW-1:0]  cMem [CMD_DEPTH];
  logic [15:0]    dMem [DATA_DEPTH];

  logic cSpace, dSpace;
  logic cPush, dPush, cPop, dPop;

  // Space is judged only from counts registered at the start of the cycle,
  // so a pop in the same cycle can never open room for a push.
  assign cSpace = notfull_q;
  assign dSpace = (dCnt_q < DATA_FULL);

  assign q_valid  = (cCnt_q != '0);
  assign wd_valid = (dCnt_q != '0);
  assign cPop     = q_valid && q_ready;
  assign dPop     = wd_valid && wd_ready;

  // Command decode and block-write beat sequencing.
  always_comb begin
    cPush   = 1'b0;
    dPush   = 1'b0;
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        case (cmd)
          3'd1, 3'd3: cPush = cSpace;
          3'd2, 3'd5, 3'd6: begin
            if (cSpace && dSpace) begin
              cPush = 1'b1;
              dPush = 1'b1;
            end
          end
          3'd4: begin
            if (cSpace && dSpace) begin
              cPush   = 1'b1;
              dPush   = 1'b1;
              // Remaining beats after the first: 8*(sz+1)-1
              beat_d  = {sz, 3'b111};
              state_d = ST_BLK;
            end
          end
          default: ;
        endcase
      end
      ST_BLK: begin
        if (dSpace) begin
          dPush  = 1'b1;
          beat_d = beat_q - 5'd1;
          if (beat_q == 5'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next occupancy of both FIFOs from their push/pop pairs.
  always_comb begin
    cCnt_d = cCnt_q;
    dCnt_d = dCnt_q;
    case ({cPush, cPop})
      2'b10:   cCnt_d = cCnt_q + 1'b1;
      2'b01:   cCnt_d = cCnt_q - 1'b1;
      default: cCnt_d = cCnt_q;
    endcase
    case ({dPush, dPop})
      2'b10:   dCnt_d = dCnt_q + 1'b1;
      2'b01:   dCnt_d = dCnt_q - 1'b1;
      default: dCnt_d = dCnt_q;
    endcase
  end

  // Control state, pointers, counts and the sticky fetching flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      cWr_q     <= '0;
      cRd_q     <= '0;
      cCnt_q    <= '0;
      dWr_q     <= '0;
      dRd_q     <= '0;
      dCnt_q    <= '0;
      notfull_q <= 1'b1;
      fetch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cCnt_q    <= cCnt_d;
      dCnt_q    <= dCnt_d;
      notfull_q <= (cCnt_d < CMD_FULL);
      if (cPush) cWr_q <= cWr_q + 1'b1;
      if (cPop)  cRd_q <= cRd_q + 1'b1;
      if (dPush) dWr_q <= dWr_q + 1'b1;
      if (dPop)  dRd_q <= dRd_q + 1'b1;
      if (fetching) fetch_q <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers guard them.
  always_ff @(posedge clk) begin
    if (cPush) cMem[cWr_q] <= {cmd, sz, op, addr};
    if (dPush) dMem[dWr_q] <= din;
  end

  assign {q_cmd, q_sz, q_op, q_addr} = q_valid ? cMem[cRd_q] : '0;
  assign wd_data    = wd_valid ? dMem[dRd_q] : '0;
  assign fillcount  = 7'(dCnt_q);
  assign notfull    = notfull_q;
  assign blk_active = (state_q == ST_BLK);
  assign drained    = fetch_q && (state_q == ST_IDLE) && (cCnt_q == '0) && (dCnt_q == '0);

endmodule
